// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg : shared widths and types for the register-file responder
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int REG_NUM_WIDTH_DEFAULT = 5;
    localparam int REG_WIDTH_DEFAULT     = 32;

    typedef logic [REG_NUM_WIDTH_DEFAULT-1:0] reg_idx_t;
    typedef logic [REG_WIDTH_DEFAULT-1:0]     reg_data_t;

    typedef struct packed {
        reg_idx_t  addr;
        reg_data_t data;
    } trace_entry_t;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ----------------------------------------------------------------------------
// trace_fifo : synchronous FIFO with wrap-bit pointers and sticky overflow
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Storage is not reset, so the head is forced to zero whenever nothing is held.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/reg_file_responder.sv
// ----------------------------------------------------------------------------
// reg_file_responder : RTL register file with write bypass and commit trace
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_file_responder
    import regfile_pkg::*;
#(
    parameter int REG_NUM_WIDTH = REG_NUM_WIDTH_DEFAULT,
    parameter int REG_WIDTH     = REG_WIDTH_DEFAULT,
    parameter int TRACE_DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ioRegFile_ioRD_en,
    input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRD_addr,
    input  logic [REG_WIDTH-1:0]     ioRegFile_ioRD_data,
    input  logic                     ioRegFile_ioRS1_en,
    input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRS1_addr,
    output logic [REG_WIDTH-1:0]     ioRegFile_ioRS1_data,
    input  logic                     ioRegFile_ioRS2_en,
    input  logic [REG_NUM_WIDTH-1:0] ioRegFile_ioRS2_addr,
    output logic [REG_WIDTH-1:0]     ioRegFile_ioRS2_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [REG_NUM_WIDTH-1:0] trace_addr,
    output logic [REG_WIDTH-1:0]     trace_data,
    output logic                     trace_overflow
);

    localparam int REG_COUNT = 2 ** REG_NUM_WIDTH;
    localparam int ENTRY_W   = REG_NUM_WIDTH + REG_WIDTH;

    logic [REG_WIDTH-1:0] regs [REG_COUNT];
    logic                 wr_eff;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   head;

    assign wr_eff = ioRegFile_ioRD_en && (ioRegFile_ioRD_addr != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_eff) begin
            regs[ioRegFile_ioRD_addr] <= ioRegFile_ioRD_data;
        end
    end

    // x0 reads as zero; a matching in-flight write is forwarded combinationally.
    always_comb begin
        ioRegFile_ioRS1_data = '0;
        if (ioRegFile_ioRS1_en && (ioRegFile_ioRS1_addr != '0)) begin
            if (ioRegFile_ioRD_en && (ioRegFile_ioRD_addr == ioRegFile_ioRS1_addr)) begin
                ioRegFile_ioRS1_data = ioRegFile_ioRD_data;
            end else begin
                ioRegFile_ioRS1_data = regs[ioRegFile_ioRS1_addr];
            end
        end
    end

    always_comb begin
        ioRegFile_ioRS2_data = '0;
        if (ioRegFile_ioRS2_en && (ioRegFile_ioRS2_addr != '0)) begin
            if (ioRegFile_ioRD_en && (ioRegFile_ioRD_addr == ioRegFile_ioRS2_addr)) begin
                ioRegFile_ioRS2_data = ioRegFile_ioRD_data;
            end else begin
                ioRegFile_ioRS2_data = regs[ioRegFile_ioRS2_addr];
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_eff),
        .push_data ({ioRegFile_ioRD_addr, ioRegFile_ioRD_data}),
        .full      (),
        .pop       (trace_valid && trace_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .overflow  (trace_overflow)
    );

    assign trace_valid              = !fifo_empty;
    assign {trace_addr, trace_data} = head;

endmodule

`default_nettype wire

// File: doc/reg_file_responder.md
Name: reg_file_responder

Overview:
- Synthesizable register-file responder for the core's ioRegFile request interface.
- Serves the same RD write port and RS1/RS2 read ports that the DPI-C register shim issues into C, but holds architectural state in RTL.
- Adds a commit-trace FIFO with a valid/ready handshake so the simulation harness can drain register writes for difftest without stalling the core.
- Sits between the decode/writeback stages and the testbench trace consumer.

Parameters:
- REG_NUM_WIDTH, 5, register index width; register count = 2**REG_NUM_WIDTH.
- REG_WIDTH, 32, register data width.
- TRACE_DEPTH, 4, trace FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- ioRegFile_ioRD_en  in  1  write request this cycle.
- ioRegFile_ioRD_addr  in  REG_NUM_WIDTH  write index.
- ioRegFile_ioRD_data  in  REG_WIDTH  write data.
- ioRegFile_ioRS1_en  in  1  read port 1 enable.
- ioRegFile_ioRS1_addr  in  REG_NUM_WIDTH  read port 1 index.
- ioRegFile_ioRS1_data  out  REG_WIDTH  read port 1 data.
- ioRegFile_ioRS2_en  in  1  read port 2 enable.
- ioRegFile_ioRS2_addr  in  REG_NUM_WIDTH  read port 2 index.
- ioRegFile_ioRS2_data  out  REG_WIDTH  read port 2 data.
- trace_valid  out  1  FIFO head entry is valid.
- trace_ready  in  1  consumer accepts the head entry.
- trace_addr  out  REG_NUM_WIDTH  head entry register index.
- trace_data  out  REG_WIDTH  head entry written value.
- trace_overflow  out  1  sticky flag: at least one trace entry was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - All registers cleared to 0.
  - FIFO emptied, read/write pointers = 0.
  - trace_valid = 0; trace_addr and trace_data = 0.
  - trace_overflow = 0.
  - Reset asserted mid-drain discards all pending entries; no partial pop occurs.
- Write:
  - When RD_en = 1 and RD_addr != 0, reg[RD_addr] <= RD_data at the rising edge.
  - Writes to x0 are ignored: no state change and no trace push.
- Read (combinational, zero latency):
  - RSn_data = 0 when RSn_en = 0 or RSn_addr = 0.
  - Otherwise, if RD_en = 1 and RD_addr == RSn_addr, RSn_data = RD_data (same-cycle write bypass).
  - Otherwise RSn_data = reg[RSn_addr].
  - RS1 and RS2 are fully independent; both may read the same index.
- Trace push:
  - Condition: an effective write, i.e. RD_en = 1 and RD_addr != 0.
  - Enqueues {RD_addr, RD_data} at the same edge as the register update.
- Trace pop:
  - Occurs on trace_valid = 1 and trace_ready = 1 at the edge.
  - trace_valid = !empty.
  - trace_addr and trace_data are driven from the head entry and must hold stable while valid && !ready.
- Simultaneous events:
  - Push and pop in the same cycle: both occur; occupancy unchanged.
  - This holds even when the FIFO is full (the pop frees the slot for the push).
  - Push into an empty FIFO: the entry becomes visible the next cycle; no same-cycle passthrough.
- Full:
  - Push with no pop while full: the new entry is dropped and trace_overflow is set.
  - The register-file write still takes effect.
  - trace_overflow stays set until reset.
- Pointers:
  - Read/write pointers are log2(TRACE_DEPTH)+1 bits.
  - Full when indices are equal and MSBs differ; empty when pointers are equal.
  - Pointers wrap naturally.
- No back-pressure is applied to the core.

Decomposition:
- Shared package (regfile_pkg):
  - REG_NUM_WIDTH and REG_WIDTH defaults.
  - Typedef reg_idx_t.
  - Typedef reg_data_t.
  - Packed struct trace_entry_t {reg_idx_t addr; reg_data_t data;}.
- Sub-module trace_fifo:
  - Generic synchronous FIFO, parameterized width and depth.
  - Interfaces: push/full, pop/empty, and a sticky overflow output.
  - The top level instantiates it once; the register array and bypass logic stay in the top level.

Test Plan:
- Reset, then read x5 and x0 with both RS enables high -> both data outputs = 0; trace_valid = 0; trace_overflow = 0.
- Write x5 = 0xDEADBEEF while RS1 reads x5 in the same cycle -> RS1_data = 0xDEADBEEF immediately (bypass).
  - Next cycle, with RD_en = 0, RS2 reads x5 -> 0xDEADBEEF.
  - One cycle after the write, trace_valid = 1 with addr = 5, data = 0xDEADBEEF.
- Write x0 = 0x1234 -> a later read of x0 returns 0; no trace entry is produced; FIFO occupancy is unchanged.
- With trace_ready = 0, write x1..x5 on consecutive cycles -> 4 entries held (x1..x4); the x5 entry is dropped; trace_overflow = 1.
  - Reg x5 still reads back its written value.
  - Set trace_ready = 1 -> the FIFO drains x1, x2, x3, x4 in order; trace_overflow remains 1.
- FIFO full with trace_ready = 1 and a write to x7 = 0x77 in the same cycle -> one pop plus one push; occupancy stays 4; no overflow.
  - x7 appears after the three older entries.
- Assert reset mid-drain with 3 entries pending -> trace_valid drops immediately (asynchronous).
  - All registers read 0 after reset is released.
  - After release, a single write produces exactly one trace entry.
